// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way write-back cache: FSM states, default geometry
// and address field extraction helpers.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      ALLOCATE,
      FLUSH
   } state_t;

   localparam int unsigned DEF_ADDR_W     = 32;
   localparam int unsigned DEF_DATA_W     = 32;
   localparam int unsigned DEF_LINE_WORDS = 4;
   localparam int unsigned DEF_NUM_SETS   = 512;

   // Fields are returned zero-extended to 64 bits; callers keep the low bits they need.
   function automatic logic [63:0] get_tag(input logic [63:0] a, input int unsigned off_w,
                                           input int unsigned idx_w);
      return a >> (off_w + idx_w);
   endfunction

   function automatic logic [63:0] get_index(input logic [63:0] a, input int unsigned off_w,
                                             input int unsigned idx_w);
      return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   function automatic logic [63:0] get_word(input logic [63:0] a, input int unsigned byte_w,
                                            input int unsigned wsel_w);
      return (a >> byte_w) & ((64'd1 << wsel_w) - 64'd1);
   endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: tag/data storage plus valid/dirty bits, single write port,
// asynchronous read at the same index. Valid/dirty clear in one reset cycle.
module cache_way_array #(
   parameter int unsigned TAG_W    = 19,
   parameter int unsigned LINE_W   = 128,
   parameter int unsigned NUM_SETS = 512,
   localparam int unsigned IDX_W   = $clog2(NUM_SETS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  idx,
   input  logic              we,
   input  logic [TAG_W-1:0]  wtag,
   input  logic [LINE_W-1:0] wline,
   input  logic              wvalid,
   input  logic              wdirty,
   output logic [TAG_W-1:0]  tag,
   output logic [LINE_W-1:0] line,
   output logic              valid,
   output logic              dirty
);

   logic [TAG_W-1:0]  tags  [NUM_SETS];
   logic [LINE_W-1:0] lines [NUM_SETS];
   logic [NUM_SETS-1:0] valids;
   logic [NUM_SETS-1:0] dirtys;

   always_ff @(posedge clk) begin
      if (reset) begin
         valids <= '0;
         dirtys <= '0;
      end else if (we) begin
         valids[idx] <= wvalid;
         dirtys[idx] <= wdirty;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tags[idx]  <= wtag;
         lines[idx] <= wline;
      end
   end

   assign tag   = tags[idx];
   assign line  = lines[idx];
   assign valid = valids[idx];
   assign dirty = dirtys[idx];

endmodule

// File: rtl/assoc_wb_cache.sv
// 2-way set-associative write-back/write-allocate cache with 1-bit LRU per set,
// req/ack line memory interface and whole-cache flush.
module assoc_wb_cache
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
   parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
   localparam int unsigned LINE_W    = LINE_WORDS * DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] dataIn,
   output logic [DATA_W-1:0] dataOut,
   output logic              cache_ready,
   output logic              hit,
   output logic              miss,
   output logic              rd_done,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int unsigned IDX_W  = $clog2(NUM_SETS);
   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
   localparam int unsigned WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;

   state_t state, state_nx;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WSEL_W-1:0] req_word;
   logic              req_rw;
   logic [DATA_W-1:0] req_data;
   logic              refill, refill_nx, victim, victim_nx;
   logic [IDX_W:0]    fcnt;
   logic [NUM_SETS-1:0] lru;

   logic capture, hit_nx, miss_nx, done_nx, fdone_nx, lru_clr, lru_we, lru_val, fcnt_inc;
   logic [DATA_W-1:0] data_nx;
   logic wr_en, wr_way, wr_valid, wr_dirty;
   logic [TAG_W-1:0]  wr_tag;
   logic [LINE_W-1:0] wr_line;

   logic [63:0] tag64, idx64, word64;
   logic        unused_bits;
   assign tag64       = get_tag(64'(addr), OFF_W, IDX_W);
   assign idx64       = get_index(64'(addr), OFF_W, IDX_W);
   assign word64      = get_word(64'(addr), BYTE_W, $clog2(LINE_WORDS));
   assign unused_bits = ^{tag64, idx64, word64};

   logic [IDX_W-1:0]  arr_idx;
   logic [TAG_W-1:0]  tag0, tag1, cur_tag;
   logic [LINE_W-1:0] line0, line1, cur_line, hit_line, merged;
   logic v0, v1, d0, d1, cur_way, cur_v, cur_d, hit0, hit1, vic_sel, vic_dirty;
   logic [DATA_W-1:0] hit_word;

   assign arr_idx = (state == FLUSH) ? fcnt[IDX_W:1] : req_idx;

   cache_way_array #(.TAG_W(TAG_W), .LINE_W(LINE_W), .NUM_SETS(NUM_SETS)) u_way0 (
      .clk(clk), .reset(reset), .idx(arr_idx), .we(wr_en && !wr_way), .wtag(wr_tag),
      .wline(wr_line), .wvalid(wr_valid), .wdirty(wr_dirty),
      .tag(tag0), .line(line0), .valid(v0), .dirty(d0)
   );

   cache_way_array #(.TAG_W(TAG_W), .LINE_W(LINE_W), .NUM_SETS(NUM_SETS)) u_way1 (
      .clk(clk), .reset(reset), .idx(arr_idx), .we(wr_en && wr_way), .wtag(wr_tag),
      .wline(wr_line), .wvalid(wr_valid), .wdirty(wr_dirty),
      .tag(tag1), .line(line1), .valid(v1), .dirty(d1)
   );

   // Flush walks ways through fcnt[0]; otherwise the recorded victim is the way in play.
   assign cur_way   = (state == FLUSH) ? fcnt[0] : victim;
   assign cur_tag   = cur_way ? tag1 : tag0;
   assign cur_line  = cur_way ? line1 : line0;
   assign cur_v     = cur_way ? v1 : v0;
   assign cur_d     = cur_way ? d1 : d0;

   assign hit0      = v0 && (tag0 == req_tag);
   assign hit1      = v1 && (tag1 == req_tag);
   assign hit_line  = hit0 ? line0 : line1;
   assign hit_word  = hit_line[req_word*DATA_W +: DATA_W];
   assign vic_sel   = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[req_idx]);
   assign vic_dirty = vic_sel ? (v1 && d1) : (v0 && d0);

   always_comb begin
      merged = hit_line;
      merged[req_word*DATA_W +: DATA_W] = req_data;
   end

   assign cache_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         req_tag    <= '0;
         req_idx    <= '0;
         req_word   <= '0;
         req_rw     <= 1'b0;
         req_data   <= '0;
         refill     <= 1'b0;
         victim     <= 1'b0;
         fcnt       <= '0;
         lru        <= '0;
         hit        <= 1'b0;
         miss       <= 1'b0;
         rd_done    <= 1'b0;
         flush_done <= 1'b0;
         dataOut    <= '0;
      end else begin
         state      <= state_nx;
         refill     <= refill_nx;
         victim     <= victim_nx;
         hit        <= hit_nx;
         miss       <= miss_nx;
         rd_done    <= done_nx;
         flush_done <= fdone_nx;
         dataOut    <= data_nx;
         if (capture) begin
            req_tag  <= tag64[TAG_W-1:0];
            req_idx  <= idx64[IDX_W-1:0];
            req_word <= word64[WSEL_W-1:0];
            req_rw   <= rw;
            req_data <= dataIn;
         end
         if (lru_clr)     lru <= '0;
         else if (lru_we) lru[req_idx] <= lru_val;
         if (fcnt_inc)    fcnt <= fcnt + 1'b1;
      end
   end

   always_comb begin
      state_nx  = state;
      capture   = 1'b0;
      hit_nx    = 1'b0;
      miss_nx   = 1'b0;
      done_nx   = 1'b0;
      fdone_nx  = 1'b0;
      data_nx   = dataOut;
      refill_nx = refill;
      victim_nx = victim;
      lru_clr   = 1'b0;
      lru_we    = 1'b0;
      lru_val   = 1'b0;
      fcnt_inc  = 1'b0;
      wr_en     = 1'b0;
      wr_way    = victim;
      wr_tag    = cur_tag;
      wr_line   = cur_line;
      wr_valid  = 1'b0;
      wr_dirty  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state)
         IDLE: begin
            if (flush_req) begin
               lru_clr  = 1'b1;
               state_nx = FLUSH;
            end else if (valid_req) begin
               capture   = 1'b1;
               refill_nx = 1'b0;
               state_nx  = COMPARE;
            end
         end
         COMPARE: begin
            if (hit0 || hit1) begin
               hit_nx   = !refill;
               done_nx  = 1'b1;
               lru_we   = 1'b1;
               lru_val  = hit0;
               data_nx  = req_rw ? hit_word : req_data;
               state_nx = IDLE;
               if (!req_rw) begin
                  wr_en    = 1'b1;
                  wr_way   = !hit0;
                  wr_tag   = req_tag;
                  wr_line  = merged;
                  wr_valid = 1'b1;
                  wr_dirty = 1'b1;
               end
            end else begin
               miss_nx   = !refill;
               victim_nx = vic_sel;
               state_nx  = vic_dirty ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {cur_tag, req_idx, {OFF_W{1'b0}}};
            mem_wdata = cur_line;
            if (mem_ack) begin
               wr_en    = 1'b1;
               wr_valid = 1'b1;
               state_nx = ALLOCATE;
            end
         end
         ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
            if (mem_ack) begin
               wr_en     = 1'b1;
               wr_tag    = req_tag;
               wr_line   = mem_rdata;
               wr_valid  = 1'b1;
               refill_nx = 1'b1;
               state_nx  = COMPARE;
            end
         end
         FLUSH: begin
            wr_way = fcnt[0];
            if (cur_v && cur_d) begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {cur_tag, fcnt[IDX_W:1], {OFF_W{1'b0}}};
               mem_wdata = cur_line;
            end
            if (!(cur_v && cur_d) || mem_ack) begin
               wr_en    = 1'b1;
               fcnt_inc = 1'b1;
               if (&fcnt) begin
                  fdone_nx = 1'b1;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache at default geometry; a line-wide RAM model answers
// mem_req after a short wait and records every write-back and fill.
module tb_assoc_wb_cache;

   logic         clk = 1'b0;
   logic         reset, valid_req, rw, flush_req, mem_ack;
   logic [31:0]  addr, dataIn, dataOut, mem_addr;
   logic         cache_ready, hit, miss, rd_done, flush_done, mem_req, mem_we;
   logic [127:0] mem_wdata, mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] mem [logic [31:0]];
   int           nwb = 0, nfill = 0, wcnt = 0;
   logic [31:0]  last_wb_addr = '0, last_fill_addr = '0;
   logic [127:0] last_wb_line = '0;
   logic         hold_ack = 1'b0;

   always #5 clk = ~clk;

   assoc_wb_cache #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .NUM_SETS(512)) dut (
      .clk(clk), .reset(reset), .valid_req(valid_req), .rw(rw), .addr(addr),
      .dataIn(dataIn), .dataOut(dataOut), .cache_ready(cache_ready), .hit(hit),
      .miss(miss), .rd_done(rd_done), .flush_req(flush_req), .flush_done(flush_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   // Untouched RAM word at byte address b reads as {16'hA5A5, b[15:0]}.
   function automatic logic [127:0] pattern_line(input logic [31:0] la);
      logic [127:0] l;
      logic [31:0]  b;
      for (int i = 0; i < 4; i++) begin
         b = la + 32'(i * 4);
         l[i*32 +: 32] = 32'hA5A5_0000 | (b & 32'h0000_FFFF);
      end
      return l;
   endfunction

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt    = 0;
         end else if (mem_req && !hold_ack && !reset) begin
            if (wcnt == 2) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  mem[mem_addr] = mem_wdata;
                  nwb++;
                  last_wb_addr = mem_addr;
                  last_wb_line = mem_wdata;
               end else begin
                  mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : pattern_line(mem_addr);
                  nfill++;
                  last_fill_addr = mem_addr;
               end
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // lat is the clock cycle (counting from the accepting edge) in which rd_done is high.
   task automatic access(input logic r, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic h, output logic m,
                         output logic [31:0] q, output logic to);
      int n = 0;
      h = 1'b0; m = 1'b0; q = '0; to = 1'b1; lat = 0;
      @(negedge clk);
      while (!cache_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      valid_req = 1'b1; rw = r; addr = a; dataIn = d;
      @(posedge clk);
      #1 valid_req = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (hit) h = 1'b1;
         if (miss) m = 1'b1;
         if (rd_done) begin
            q = dataOut; lat = k + 1; to = 1'b0;
            break;
         end
      end
   endtask

   task automatic run_flush(input logic with_req, output int cyc, output logic done,
                            output logic stray);
      cyc = 0; done = 1'b0; stray = 1'b0;
      @(negedge clk);
      flush_req = 1'b1; valid_req = with_req; rw = 1'b1; addr = 32'h0000_0020;
      @(posedge clk);
      #1 flush_req = 1'b0; valid_req = 1'b0;
      while (!done && cyc < 4000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (rd_done) stray = 1'b1;
         if (flush_done) done = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; valid_req = 1'b0; rw = 1'b1; addr = '0; dataIn = '0; flush_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({cache_ready, hit, miss, rd_done, flush_done, mem_req, mem_we} !== 7'b100_0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 1000000",
                  {cache_ready, hit, miss, rd_done, flush_done, mem_req, mem_we});
      end
      n_checks++;
      if ({dataOut, mem_addr} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {dataOut, mem_addr});
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_cold_read();
      int lat; logic h, m, to; logic [31:0] q;
      int f0 = nfill, w0 = nwb;
      access(1'b1, 32'h20, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, h, m} !== 3'b001) begin
         n_fail++; $display("FAIL cold_flags: got %b expected 001", {to, h, m});
      end
      n_checks++;
      if ({nfill - f0, nwb - w0} !== {32'd1, 32'd0}) begin
         n_fail++; $display("FAIL cold_mem_ops: fills %0d wbs %0d expected 1 0", nfill - f0, nwb - w0);
      end
      n_checks++;
      if (last_fill_addr !== 32'h20) begin
         n_fail++; $display("FAIL cold_fill_addr: got %h expected 00000020", last_fill_addr);
      end
      n_checks++;
      if (q !== 32'hA5A5_0020) begin
         n_fail++; $display("FAIL cold_data: got %h expected a5a50020", q);
      end
   endtask

   task automatic test_read_hit();
      int lat; logic h, m, to; logic [31:0] q;
      int f0 = nfill, w0 = nwb;
      access(1'b1, 32'h20, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, h, m} !== 3'b010) begin
         n_fail++; $display("FAIL hit_flags: got %b expected 010", {to, h, m});
      end
      n_checks++;
      if (lat !== 2) begin
         n_fail++; $display("FAIL hit_latency: got %0d expected 2", lat);
      end
      n_checks++;
      if ((nfill - f0) + (nwb - w0) !== 0) begin
         n_fail++; $display("FAIL hit_no_mem: got %0d mem ops expected 0", (nfill - f0) + (nwb - w0));
      end
      n_checks++;
      if (q !== 32'hA5A5_0020) begin
         n_fail++; $display("FAIL hit_data: got %h expected a5a50020", q);
      end
   endtask

   task automatic test_fill_both_ways();
      int lat; logic h, m, to; logic [31:0] q;
      int w0 = nwb;
      access(1'b0, 32'h10, 32'h1ff, lat, h, m, q, to);
      n_checks++;
      if ({to, m, last_fill_addr} !== {2'b01, 32'h10}) begin
         n_fail++; $display("FAIL wr_cold: got to/miss %b fill %h expected 01 00000010", {to, m}, last_fill_addr);
      end
      access(1'b1, 32'h2010, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, m, last_fill_addr} !== {2'b01, 32'h2010}) begin
         n_fail++; $display("FAIL way1_fill: got to/miss %b fill %h expected 01 00002010", {to, m}, last_fill_addr);
      end
      n_checks++;
      if (nwb - w0 !== 0 || q !== 32'hA5A5_2010) begin
         n_fail++; $display("FAIL way1_data: wbs %0d data %h expected 0 a5a52010", nwb - w0, q);
      end
   endtask

   task automatic test_lru_writeback();
      int lat; logic h, m, to; logic [31:0] q, w0_word;
      int w0 = nwb;
      access(1'b1, 32'h4010, '0, lat, h, m, q, to);
      w0_word = last_wb_line[31:0];
      n_checks++;
      if ({to, m, nwb - w0} !== {2'b01, 32'd1}) begin
         n_fail++; $display("FAIL evict_dirty: to/miss %b wbs %0d expected 01 1", {to, m}, nwb - w0);
      end
      n_checks++;
      if ({last_wb_addr, w0_word} !== {32'h10, 32'h1ff}) begin
         n_fail++; $display("FAIL wb_content: addr %h word0 %h expected 00000010 000001ff", last_wb_addr, w0_word);
      end
      n_checks++;
      if ({last_fill_addr, q} !== {32'h4010, 32'hA5A5_4010}) begin
         n_fail++; $display("FAIL evict_refill: fill %h data %h expected 00004010 a5a54010", last_fill_addr, q);
      end
      w0 = nwb;
      access(1'b1, 32'h10, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, m, nwb - w0, q} !== {2'b01, 32'd0, 32'h1ff}) begin
         n_fail++; $display("FAIL evict_clean: to/miss %b wbs %0d data %h expected 01 0 000001ff", {to, m}, nwb - w0, q);
      end
      access(1'b1, 32'h4018, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, h, q} !== {2'b01, 32'hA5A5_4018}) begin
         n_fail++; $display("FAIL word_select: to/hit %b data %h expected 01 a5a54018", {to, h}, q);
      end
   endtask

   task automatic test_flush();
      int lat, cyc; logic h, m, to, done, stray; logic [31:0] q, w1_word;
      int w0;
      access(1'b0, 32'h20, 32'hDEAD_0020, lat, h, m, q, to);
      access(1'b0, 32'h34, 32'hBEEF_0034, lat, h, m, q, to);
      access(1'b1, 32'h34, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, h, q} !== {2'b01, 32'hBEEF_0034}) begin
         n_fail++; $display("FAIL write_merge: to/hit %b data %h expected 01 beef0034", {to, h}, q);
      end
      w0 = nwb;
      run_flush(1'b0, cyc, done, stray);
      w1_word = last_wb_line[63:32];
      n_checks++;
      if ({done, nwb - w0} !== {1'b1, 32'd2}) begin
         n_fail++; $display("FAIL flush_dirty: done %b wbs %0d expected 1 2", done, nwb - w0);
      end
      n_checks++;
      if ({last_wb_addr, w1_word} !== {32'h30, 32'hBEEF_0034}) begin
         n_fail++; $display("FAIL flush_wb_last: addr %h word1 %h expected 00000030 beef0034", last_wb_addr, w1_word);
      end
      access(1'b1, 32'h20, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, m, q} !== {2'b01, 32'hDEAD_0020}) begin
         n_fail++; $display("FAIL post_flush_miss: to/miss %b data %h expected 01 dead0020", {to, m}, q);
      end
      access(1'b1, 32'h28, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, h, q} !== {2'b01, 32'hA5A5_0028}) begin
         n_fail++; $display("FAIL post_flush_hit: to/hit %b data %h expected 01 a5a50028", {to, h}, q);
      end
      w0 = nwb;
      run_flush(1'b1, cyc, done, stray);
      n_checks++;
      if ({done, cyc, nwb - w0} !== {1'b1, 32'd1024, 32'd0}) begin
         n_fail++; $display("FAIL clean_flush_len: done %b cycles %0d wbs %0d expected 1 1024 0", done, cyc, nwb - w0);
      end
      n_checks++;
      if (stray !== 1'b0) begin
         n_fail++; $display("FAIL flush_priority: rd_done during flush %b expected 0", stray);
      end
   endtask

   task automatic test_reset_mid_wb();
      int lat, n; logic h, m, to; logic [31:0] q;
      int w0;
      access(1'b0, 32'h40, 32'h1, lat, h, m, q, to);
      access(1'b0, 32'h2040, 32'h2, lat, h, m, q, to);
      hold_ack = 1'b1;
      @(negedge clk);
      valid_req = 1'b1; rw = 1'b1; addr = 32'h4040;
      @(posedge clk);
      #1 valid_req = 1'b0;
      n = 0;
      while (!(mem_req && mem_we) && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if ({mem_req, mem_we, mem_addr} !== {2'b11, 32'h40}) begin
         n_fail++; $display("FAIL mid_wb_req: req/we %b addr %h expected 11 00000040", {mem_req, mem_we}, mem_addr);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({mem_req, cache_ready} !== 2'b01) begin
         n_fail++; $display("FAIL reset_abandon: req/ready %b expected 01", {mem_req, cache_ready});
      end
      @(negedge clk);
      reset = 1'b0; hold_ack = 1'b0;
      w0 = nwb;
      access(1'b1, 32'h4040, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, m, nwb - w0} !== {2'b01, 32'd0}) begin
         n_fail++; $display("FAIL reread_miss: to/miss %b wbs %0d expected 01 0", {to, m}, nwb - w0);
      end
      access(1'b1, 32'h40, '0, lat, h, m, q, to);
      n_checks++;
      if ({to, m, q} !== {2'b01, 32'hA5A5_0040}) begin
         n_fail++; $display("FAIL lost_dirty: to/miss %b data %h expected 01 a5a50040", {to, m}, q);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_cold_read();
      test_read_hit();
      test_fill_both_ways();
      test_lru_writeback();
      test_flush();
      test_reset_mid_wb();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
